// File: rtl/image_stream_pkg.sv
// Shared definitions for the image stream source.
// Contents: controller state encoding, label width, default image geometry
// and a helper that gives a safe (non-zero) address width for small counts.
package image_stream_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        NET_RST  = 3'd1,
        WAIT_RDY = 3'd2,
        STREAM   = 3'd3,
        WAIT_RES = 3'd4
    } state_t;

    localparam int LABEL_BITS  = 4;
    localparam int DEF_HEIGHT  = 28;
    localparam int DEF_WIDTH   = 28;
    localparam int DEF_PIX     = DEF_HEIGHT * DEF_WIDTH;

    // Width able to index n entries; never returns zero.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer between the 1-cycle-latency pixel memory and the
// valid/ready pixel interface. The head entry drives the output and does not
// move until it is accepted, so data stays stable across stalls.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write one entry (caller guarantees room)
//   valid, ready      output handshake; pop = valid & ready
//   data              head entry (0 after reset)
//   count             current occupancy, 0..2
module stream_skid_buf #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    output logic                 valid,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic [1:0]           count
);

    logic [DATA_BITS-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 pop;

    assign valid = (count != 2'd0);
    assign pop   = valid & ready;
    assign data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/image_stream_source.sv
// Image stream source: replaces the bench-side pixel feeder of full_network.
// For each of NUM_IMAGES images it pulses the network reset, fetches the label,
// streams HEIGHT*WIDTH pixels from pixel memory over valid/ready, then waits
// for the network result (or a timeout) and accumulates accuracy counters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a run (honoured in IDLE only)
//   pix_addr/rd_en/rdata      pixel memory, 1-cycle read latency
//   lbl_addr/rd_en/rdata      label memory, 1-cycle read latency
//   net_rst_n                 active-low reset to the network
//   data_out, valid_out       pixel stream to network; ready_in from network
//   class_in, result_valid    network classification and its valid level
//   busy, done                run in progress / one-cycle end-of-run pulse
//   image_count, correct_count, last_pred, timeout_err   run statistics
module image_stream_source
    import image_stream_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int HEIGHT         = DEF_HEIGHT,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int NUM_IMAGES     = 10,
    parameter int NET_RST_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int PIX           = HEIGHT * WIDTH,
    localparam int PADDR_BITS    = $clog2(NUM_IMAGES * PIX),
    localparam int CNT_BITS      = $clog2(NUM_IMAGES + 1),
    localparam int LADDR_BITS    = bits_for(NUM_IMAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [PADDR_BITS-1:0] pix_addr,
    output logic                  pix_rd_en,
    input  logic [DATA_BITS-1:0]  pix_rdata,
    output logic [LADDR_BITS-1:0] lbl_addr,
    output logic                  lbl_rd_en,
    input  logic [LABEL_BITS-1:0] lbl_rdata,
    output logic                  net_rst_n,
    output logic [DATA_BITS-1:0]  data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    input  logic [LABEL_BITS-1:0] class_in,
    input  logic                  result_valid,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_BITS-1:0]   image_count,
    output logic [CNT_BITS-1:0]   correct_count,
    output logic [LABEL_BITS-1:0] last_pred,
    output logic                  timeout_err
);

    localparam int IDX_BITS = $clog2(PIX + 1);
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NRC_BITS = bits_for(NET_RST_CYCLES);

    state_t state;
    state_t state_next;

    logic [LADDR_BITS-1:0] img;
    logic [PADDR_BITS-1:0] pix_base;
    logic [IDX_BITS-1:0]   rd_idx;
    logic [IDX_BITS-1:0]   xfer_cnt;
    logic [NRC_BITS-1:0]   rst_cnt;
    logic [TMO_BITS-1:0]   tmo_cnt;
    logic [LABEL_BITS-1:0] label;
    logic                  rd_vld_p1;
    logic                  lbl_vld_p1;
    logic [1:0]            buf_count;
    logic                  pop;
    logic                  room;
    logic                  last_xfer;
    logic                  res_hit;
    logic                  tmo_hit;
    logic                  img_last;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == CNT_BITS'(NUM_IMAGES)) ? v : v + 1'b1;
    endfunction

    // Stage p0: read issue. A new read is allowed only if, after this edge's
    // pop and the in-flight word landing, at most one entry is occupied, so
    // the word it returns always finds a free slot.
    assign pop       = valid_out & ready_in;
    assign room      = ({1'b0, buf_count} + {2'b00, rd_vld_p1}) <= ({2'b00, pop} + 3'd1);
    assign pix_rd_en = (state == STREAM) && (rd_idx != IDX_BITS'(PIX)) && room;
    assign pix_addr  = pix_base + PADDR_BITS'(rd_idx);
    assign lbl_rd_en = (state == NET_RST) && (rst_cnt == '0);
    assign lbl_addr  = img;

    assign last_xfer = pop && (xfer_cnt == IDX_BITS'(PIX - 1));
    assign res_hit   = (state == WAIT_RES) && result_valid;
    // A result arriving on the timeout cycle takes priority.
    assign tmo_hit   = (state == WAIT_RES) && !result_valid &&
                       (tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES));
    assign img_last  = (img == LADDR_BITS'(NUM_IMAGES - 1));

    // Stage p1: memory data returns and enters the skid buffer.
    stream_skid_buf #(
        .DATA_BITS (DATA_BITS)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_vld_p1),
        .push_data (pix_rdata),
        .valid     (valid_out),
        .ready     (ready_in),
        .data      (data_out),
        .count     (buf_count)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (start) state_next = NET_RST;
            NET_RST:  if (rst_cnt == NRC_BITS'(NET_RST_CYCLES - 1)) state_next = WAIT_RDY;
            WAIT_RDY: if (ready_in) state_next = STREAM;
            STREAM:   if (last_xfer) state_next = WAIT_RES;
            WAIT_RES: if (res_hit || tmo_hit) state_next = img_last ? IDLE : NET_RST;
            default:  state_next = IDLE;
        endcase
    end

    // Label is reloaded for every image, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lbl_vld_p1) begin
            label <= lbl_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            net_rst_n     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            img           <= '0;
            pix_base      <= '0;
            rd_idx        <= '0;
            xfer_cnt      <= '0;
            rst_cnt       <= '0;
            tmo_cnt       <= '0;
            rd_vld_p1     <= 1'b0;
            lbl_vld_p1    <= 1'b0;
            image_count   <= '0;
            correct_count <= '0;
            last_pred     <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state      <= state_next;
            net_rst_n  <= (state_next != NET_RST);
            busy       <= (state_next != IDLE);
            done       <= (state == WAIT_RES) && (state_next == IDLE);
            rd_vld_p1  <= pix_rd_en;
            lbl_vld_p1 <= lbl_rd_en;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        image_count   <= '0;
                        correct_count <= '0;
                        timeout_err   <= 1'b0;
                        img           <= '0;
                        pix_base      <= '0;
                        rst_cnt       <= '0;
                    end
                end
                NET_RST: begin
                    rd_idx   <= '0;
                    xfer_cnt <= '0;
                    if (rst_cnt == NRC_BITS'(NET_RST_CYCLES - 1)) begin
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (pix_rd_en) rd_idx   <= rd_idx + 1'b1;
                    if (pop)       xfer_cnt <= xfer_cnt + 1'b1;
                    if (last_xfer) tmo_cnt  <= '0;
                end
                WAIT_RES: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (res_hit) begin
                        last_pred   <= class_in;
                        image_count <= sat_inc(image_count);
                        if (class_in == label) begin
                            correct_count <= sat_inc(correct_count);
                        end
                    end else if (tmo_hit) begin
                        image_count <= sat_inc(image_count);
                        timeout_err <= 1'b1;
                    end
                    if ((res_hit || tmo_hit) && !img_last) begin
                        img      <= img + 1'b1;
                        pix_base <= pix_base + PADDR_BITS'(PIX);
                        rst_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_stream_source.sv
// Testbench for image_stream_source: pixel/label memories and a network model,
// randomized ready and result timing, checked against expectations derived
// from the memory contents and the per-image prediction table.
module tb_image_stream_source;

    localparam int DATA_BITS  = 8;
    localparam int N          = 3;
    localparam int PIX        = 784;
    localparam int TMO        = 100;
    localparam int NRC        = 2;
    localparam int PADDR_BITS = 12;
    localparam int CNT_BITS   = 2;
    localparam int LADDR_BITS = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [PADDR_BITS-1:0] pix_addr;
    logic                  pix_rd_en;
    logic [DATA_BITS-1:0]  pix_rdata;
    logic [LADDR_BITS-1:0] lbl_addr;
    logic                  lbl_rd_en;
    logic [3:0]            lbl_rdata;
    logic                  net_rst_n;
    logic [DATA_BITS-1:0]  data_out;
    logic                  valid_out;
    logic                  ready_in;
    logic [3:0]            class_in;
    logic                  result_valid;
    logic                  busy;
    logic                  done;
    logic [CNT_BITS-1:0]   image_count;
    logic [CNT_BITS-1:0]   correct_count;
    logic [3:0]            last_pred;
    logic                  timeout_err;

    logic [DATA_BITS-1:0]  pix_mem [N*PIX];
    logic [3:0]            lbl_mem [N];
    int                    pred [N];
    int                    lp_model;
    int                    n_chk;
    int                    n_fail;

    always #5 clk = ~clk;

    image_stream_source #(
        .DATA_BITS      (DATA_BITS),
        .HEIGHT         (28),
        .WIDTH          (28),
        .NUM_IMAGES     (N),
        .NET_RST_CYCLES (NRC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pix_addr      (pix_addr),
        .pix_rd_en     (pix_rd_en),
        .pix_rdata     (pix_rdata),
        .lbl_addr      (lbl_addr),
        .lbl_rd_en     (lbl_rd_en),
        .lbl_rdata     (lbl_rdata),
        .net_rst_n     (net_rst_n),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .class_in      (class_in),
        .result_valid  (result_valid),
        .busy          (busy),
        .done          (done),
        .image_count   (image_count),
        .correct_count (correct_count),
        .last_pred     (last_pred),
        .timeout_err   (timeout_err)
    );

    // Synchronous-read memories.
    always @(posedge clk) begin
        if (pix_rd_en) pix_rdata <= pix_mem[pix_addr];
        if (lbl_rd_en) lbl_rdata <= lbl_mem[lbl_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_pixels();
        for (int i = 0; i < N*PIX; i++) pix_mem[i] = DATA_BITS'($urandom);
    endtask

    // all_ok: every prediction matches its label; otherwise about half do.
    task automatic random_tables(input bit all_ok);
        for (int i = 0; i < N; i++) begin
            lbl_mem[i] = 4'($urandom_range(0, 9));
            if (all_ok || ($urandom_range(0, 1) == 0)) pred[i] = int'(lbl_mem[i]);
            else pred[i] = (int'(lbl_mem[i]) + $urandom_range(1, 9)) % 10;
        end
    endtask

    task automatic run_images(input bit stalls, input bit tmo_mode, input bit glitch, input int rst_at);
        int cyc, xfers, pix_err, viol, done_cnt, res_wait, img_res, t_last0, gap;
        int lowrun, nr_runs, nr_err, stall, post, limit, exp_corr;
        bit hold, got_addr, done_seen, ended, busy_mid, got_mid;
        logic [DATA_BITS-1:0]  hold_data;
        logic [PADDR_BITS-1:0] first_addr;
        logic [CNT_BITS-1:0]   prev_ic;
        cyc = 0; xfers = 0; pix_err = 0; viol = 0; done_cnt = 0; res_wait = 0;
        img_res = 0; t_last0 = -1; gap = -1; lowrun = 0; nr_runs = 0; nr_err = 0;
        stall = 0; post = 0; hold = 0; got_addr = 0; done_seen = 0; ended = 0;
        busy_mid = 0; got_mid = 0; hold_data = '0; first_addr = '0;
        prev_ic = image_count;
        limit = N * (PIX * 8 + 300) + 100;
        exp_corr = 0;
        for (int i = 0; i < N; i++) if (!tmo_mode && pred[i] == int'(lbl_mem[i])) exp_corr++;

        while (!ended) begin
            @(negedge clk);
            cyc++;
            // observe the state left by the previous edge
            if (hold && (!valid_out || data_out !== hold_data)) viol++;
            if (done) begin done_cnt++; done_seen = 1; end
            if (image_count > prev_ic && gap < 0 && t_last0 >= 0) gap = cyc - t_last0;
            prev_ic = image_count;
            if (!net_rst_n) lowrun++;
            else begin
                if (lowrun > 0) begin
                    nr_runs++;
                    if (lowrun != NRC) nr_err++;
                end
                lowrun = 0;
            end
            if (pix_rd_en && !got_addr) begin got_addr = 1; first_addr = pix_addr; end
            if (xfers == 10 && !got_mid) begin got_mid = 1; busy_mid = busy; end

            // drive inputs for the next edge
            start = (cyc == 1) || (glitch && xfers == 100);
            if (!stalls) ready_in = 1'b1;
            else if (stall > 0) begin stall--; ready_in = 1'b0; end
            else if ($urandom_range(0, 15) == 0) begin
                stall = $urandom_range(1, 5) - 1;
                ready_in = 1'b0;
            end else ready_in = ~ready_in;
            result_valid = 1'b0;
            class_in = 4'd0;
            if (res_wait > 0) begin
                res_wait--;
                if (res_wait == 0) begin
                    result_valid = 1'b1;
                    class_in = 4'(pred[img_res]);
                end
            end else if (glitch && !net_rst_n) begin
                result_valid = 1'b1;
                class_in = 4'($urandom_range(0, 9));
            end

            if (rst_at >= 0 && xfers == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                result_valid = 1'b0;
                chk("midrst_valid_out", 32'(valid_out), 0);
                chk("midrst_net_rst_n", 32'(net_rst_n), 0);
                chk("midrst_busy", 32'(busy), 0);
                chk("midrst_image_count", 32'(image_count), 0);
                chk("midrst_correct_count", 32'(correct_count), 0);
                chk("midrst_last_pred", 32'(last_pred), 0);
                chk("midrst_pix_rd_en", 32'(pix_rd_en), 0);
                lp_model = 0;
                return;
            end

            // network side of the handshake at the coming edge
            if (valid_out && ready_in) begin
                if (xfers >= N*PIX || data_out !== pix_mem[xfers]) pix_err++;
                xfers++;
                if (xfers % PIX == 0) begin
                    if (t_last0 < 0) t_last0 = cyc + 1;
                    img_res = xfers / PIX - 1;
                    if (!tmo_mode) res_wait = $urandom_range(0, 20) + 1;
                end
            end
            hold = valid_out && !ready_in;
            hold_data = data_out;

            if (done_seen) post++;
            if (post == 4) ended = 1;
            if (cyc >= limit) begin
                chk("run_done_in_budget", 32'(done_seen), 1);
                ended = 1;
            end
        end
        start = 1'b0;
        result_valid = 1'b0;

        chk("transfers", 32'(xfers), 32'(N*PIX));
        chk("pixel_order_errors", 32'(pix_err), 0);
        chk("stall_stability_errors", 32'(viol), 0);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("busy_mid_run", 32'(busy_mid), 1);
        chk("busy_end", 32'(busy), 0);
        chk("image_count", 32'(image_count), 32'(N));
        chk("correct_count", 32'(correct_count), 32'(exp_corr));
        if (!tmo_mode) lp_model = pred[N-1];
        chk("last_pred", 32'(last_pred), 32'(lp_model));
        chk("timeout_err", 32'(timeout_err), 32'(tmo_mode));
        chk("net_rst_pulses", 32'(nr_runs), 32'(N));
        chk("net_rst_len_errors", 32'(nr_err), 0);
        chk("first_read_addr", got_addr ? 32'(first_addr) : 32'hFFFF_FFFF, 0);
        if (tmo_mode) chk("timeout_gap", 32'(gap), 32'(TMO + 1));
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        lp_model = 0;
        rst = 1'b1;
        start = 1'b0;
        ready_in = 1'b0;
        class_in = 4'd0;
        result_valid = 1'b0;
        fill_pixels();
        lbl_mem[0] = 4'd7; lbl_mem[1] = 4'd3; lbl_mem[2] = 4'd2;
        pred[0] = 7; pred[1] = 5; pred[2] = 5;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_net_rst_n", 32'(net_rst_n), 0);
        chk("rst_pix_rd_en", 32'(pix_rd_en), 0);
        chk("rst_lbl_rd_en", 32'(lbl_rd_en), 0);
        chk("rst_counts", 32'({image_count, correct_count}), 0);
        chk("rst_last_pred", 32'(last_pred), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_net_rst_n", 32'(net_rst_n), 1);

        // fixed labels {7,3,2}, predictions {7,5,5}: one correct, last_pred 5
        run_images(1'b0, 1'b0, 1'b0, -1);

        // ready toggling with random stalls, ignored start/result glitches
        fill_pixels();
        random_tables(1'b0);
        run_images(1'b1, 1'b0, 1'b1, -1);

        // network never answers: every image times out
        fill_pixels();
        run_images(1'b0, 1'b1, 1'b0, -1);

        // reset in the middle of image 1, then a clean full run
        random_tables(1'b0);
        run_images(1'b0, 1'b0, 1'b0, PIX + 400);
        run_images(1'b1, 1'b0, 1'b0, -1);

        // every prediction correct: counters reach NUM_IMAGES
        fill_pixels();
        random_tables(1'b1);
        run_images(1'b0, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/image_stream_source.md
Name: image_stream_source

Overview:
- Hardware replacement for the bench-side pixel feeder in front of full_network.
- For each image, reads pixels and expected labels from an external synchronous-read memory.
- Pulses the network reset, then streams HEIGHT*WIDTH pixels over the valid/ready pixel interface.
- Waits for valid_out_network, scores class_out against the label, and accumulates accuracy over NUM_IMAGES images.

Parameters:
DATA_BITS, 8, pixel width
HEIGHT, 28, image rows
WIDTH, 28, image columns
NUM_IMAGES, 10, images per run
NET_RST_CYCLES, 2, cycles net_rst_n held low before each image
TIMEOUT_CYCLES, 65536, max cycles waiting for a result
(derived) PIX = HEIGHT*WIDTH; PADDR_BITS = $clog2(NUM_IMAGES*PIX); CNT_BITS = $clog2(NUM_IMAGES+1)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin run; sampled in IDLE only
pix_addr  out  PADDR_BITS  pixel memory address, img*PIX + i
pix_rd_en  out  1  pixel memory read strobe
pix_rdata  in  DATA_BITS  pixel read data, valid 1 cycle after pix_rd_en
lbl_addr  out  $clog2(NUM_IMAGES)  label memory address
lbl_rd_en  out  1  label read strobe
lbl_rdata  in  4  label data, 1-cycle latency
net_rst_n  out  1  active-low reset to full_network
data_out  out  DATA_BITS  pixel to network data_in
valid_out  out  1  to network valid_in
ready_in  in  1  from network ready
class_in  in  4  network class_out
result_valid  in  1  network valid_out_network (level)
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
image_count  out  CNT_BITS  images completed, including timeouts
correct_count  out  CNT_BITS  predictions matching label
last_pred  out  4  most recent class_in captured
timeout_err  out  1  sticky; set on any timeout, cleared by start

Behaviour:
- Reset values:
  - busy = 0, done = 0, valid_out = 0, data_out = 0, net_rst_n = 0.
  - pix_rd_en = 0, lbl_rd_en = 0, all counters = 0, last_pred = 0, timeout_err = 0.
  - FSM enters IDLE.
- Reset mid-run: everything returns to the reset values on the next edge and any in-flight transfer is abandoned. No partial state survives.
- IDLE:
  - net_rst_n = 1.
  - start = 1: clear image_count, correct_count and timeout_err; img = 0; busy = 1; go to NET_RST.
- NET_RST:
  - net_rst_n = 0 for exactly NET_RST_CYCLES cycles.
  - Issue lbl_rd_en for img; latch lbl_rdata 1 cycle later.
  - Then go to WAIT_RDY.
- WAIT_RDY: net_rst_n = 1; go to STREAM on the first cycle ready_in = 1.
- STREAM:
  - Transfer occurs on a clk edge with valid_out & ready_in.
  - Once asserted, valid_out stays high and data_out stays stable until the transfer.
  - Pixels are sent in address order, with no drops or duplicates.
  - Memory latency is hidden by a 2-entry skid buffer: 1 pixel/cycle while ready_in stays high.
  - First valid_out occurs no later than 2 cycles after entering STREAM.
  - Reads are never issued when the buffer could overflow.
  - After transfer PIX, valid_out = 0 on the next cycle; go to WAIT_RES and reset the timeout counter.
- WAIT_RES:
  - First cycle with result_valid = 1: last_pred = class_in; image_count += 1; correct_count += 1 if class_in == label.
  - Timeout counter reaching TIMEOUT_CYCLES: image_count += 1; timeout_err = 1; correct_count unchanged.
  - Either event, with img < NUM_IMAGES-1: img += 1, go to NET_RST.
  - Either event, otherwise: done = 1 for one cycle, busy = 0, go to IDLE.
  - result_valid and timeout on the same cycle: the result wins.
- result_valid outside WAIT_RES is ignored. start outside IDLE is ignored.
- Counters saturate at NUM_IMAGES and never wrap.

Decomposition:
- Package image_stream_pkg:
  - FSM state enum {IDLE, NET_RST, WAIT_RDY, STREAM, WAIT_RES}.
  - PIX and width localparams.
- Sub-module stream_skid_buf (2-entry, DATA_BITS wide): provides the valid/ready decoupling from the 1-cycle-latency memory.

Test Plan:
- NUM_IMAGES = 2, ready_in always 1, labels {7, 3}, network model returns 7 then 5 → 784 transfers per image in address order, image_count = 2, correct_count = 1, last_pred = 5, single done pulse.
- ready_in toggling 1/0 every cycle plus random 1–5 cycle stalls → data_out stable during stalls, exactly 784 transfers, pixel sequence equals memory contents 0..783.
- result_valid never asserted, TIMEOUT_CYCLES = 100 → image_count increments 101 cycles after the last transfer, timeout_err = 1, next image proceeds with net_rst_n low for 2 cycles.
- Assert rst during pixel 400 of image 0 → next cycle valid_out = 0, net_rst_n = 0, busy = 0, counters = 0; a new start restarts at address 0.
- start pulsed during STREAM, and result_valid pulsed during NET_RST → both ignored, counts unchanged.
- NUM_IMAGES = 10 with all predictions correct → correct_count = 10, counters saturate, done asserted exactly once.
